// File: rtl/dt_pkg.sv
// Shared geometry, address widths and state encoding for the distance-transform memory host.
package dt_pkg;

    localparam int unsigned IMG_W     = 128;
    localparam int unsigned IMG_H     = 128;
    localparam int unsigned STI_DW    = 16;
    localparam int unsigned RES_DW    = 8;
    localparam int unsigned STI_WORDS = IMG_W * IMG_H / STI_DW;
    localparam int unsigned RES_WORDS = IMG_W * IMG_H;
    localparam int unsigned STI_AW    = $clog2(STI_WORDS);
    localparam int unsigned RES_AW    = $clog2(RES_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP
    } state_e;

endpackage

// File: rtl/dt_mem_host_if.sv
// Host stream and engine memory signals of the distance-transform memory host.
interface dt_mem_host_if;
    import dt_pkg::*;

    logic              start;
    logic              in_valid;
    logic [STI_DW-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [RES_DW-1:0] out_data;
    logic              out_last;
    logic              out_ready;
    logic              busy;
    logic              dt_reset;
    logic              done;
    logic              sti_rd;
    logic [STI_AW-1:0] sti_addr;
    logic [STI_DW-1:0] sti_di;
    logic              res_wr;
    logic              res_rd;
    logic [RES_AW-1:0] res_addr;
    logic [RES_DW-1:0] res_do;
    logic [RES_DW-1:0] res_di;

    // Memory host side.
    modport slave (
        input  start, in_valid, in_data, out_ready, done,
        input  sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do,
        output in_ready, out_valid, out_data, out_last, busy, dt_reset, sti_di, res_di
    );

    // Host and engine side.
    modport master (
        output start, in_valid, in_data, out_ready, done,
        output sti_rd, sti_addr, res_wr, res_rd, res_addr, res_do,
        input  in_ready, out_valid, out_data, out_last, busy, dt_reset, sti_di, res_di
    );

endinterface

// File: rtl/dt_res_ram.sv
// Result map: one synchronous write port, two asynchronous read ports (engine and dump).
module dt_res_ram
    import dt_pkg::*;
#(
    parameter int unsigned DEPTH = RES_WORDS,
    parameter int unsigned AW    = RES_AW,
    parameter int unsigned DW    = RES_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write shows up one cycle later.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dt_mem_host.sv
// Memory-side responder for the distance-transform engine: loads the source image,
// clears the result map, runs the engine, then streams the result map back to the host.
module dt_mem_host
    import dt_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    dt_mem_host_if.slave  bus
);

    state_e              state_q, state_d;
    logic [STI_AW-1:0]   word_cnt_q, word_cnt_d;
    logic                words_done_q, words_done_d;
    logic [RES_AW-1:0]   res_cnt_q, res_cnt_d;
    logic                clear_done_q, clear_done_d;
    logic                dt_reset_q, dt_reset_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [RES_DW-1:0]   out_data_q, out_data_d;

    logic                word_accept;
    logic                sti_we;
    logic                ram_we;
    logic [RES_AW-1:0]   ram_waddr;
    logic [RES_DW-1:0]   ram_wdata;
    logic [RES_DW-1:0]   dump_rdata;
    logic                unused_rd;

    logic [STI_DW-1:0]   sti_mem [STI_WORDS];

    assign unused_rd   = bus.sti_rd ^ bus.res_rd;
    assign word_accept = (state_q == LOAD) && !words_done_q && bus.in_valid;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        words_done_d = words_done_q;
        res_cnt_d    = res_cnt_q;
        clear_done_d = clear_done_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        sti_we       = 1'b0;
        ram_we       = 1'b0;
        ram_waddr    = bus.res_addr;
        ram_wdata    = bus.res_do;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = LOAD;
                    word_cnt_d   = '0;
                    words_done_d = 1'b0;
                    res_cnt_d    = '0;
                    clear_done_d = 1'b0;
                end
            end
            LOAD: begin
                if (word_accept) begin
                    sti_we     = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == '1) begin
                        words_done_d = 1'b1;
                    end
                end
                // Clearing runs every cycle regardless of the host handshake.
                if (!clear_done_q) begin
                    ram_we    = 1'b1;
                    ram_waddr = res_cnt_q;
                    ram_wdata = '0;
                    res_cnt_d = res_cnt_q + 1'b1;
                    if (res_cnt_q == '1) begin
                        clear_done_d = 1'b1;
                    end
                end
                if ((clear_done_q || (res_cnt_q == '1)) &&
                    (words_done_q || (word_accept && (word_cnt_q == '1)))) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ram_we = bus.res_wr;
                if (bus.done) begin
                    state_d   = DUMP;
                    res_cnt_d = '0;
                end
            end
            DUMP: begin
                if (out_valid_q && bus.out_ready && out_last_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (!out_valid_q || bus.out_ready) begin
                    out_valid_d = 1'b1;
                    out_data_d  = dump_rdata;
                    out_last_d  = (res_cnt_q == '1);
                    res_cnt_d   = res_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        dt_reset_d = (state_q == RUN) && !bus.done;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            words_done_q <= 1'b0;
            res_cnt_q    <= '0;
            clear_done_q <= 1'b0;
            dt_reset_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            words_done_q <= words_done_d;
            res_cnt_q    <= res_cnt_d;
            clear_done_q <= clear_done_d;
            dt_reset_q   <= dt_reset_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
        end
    end

    // A reset edge must not commit a partial transfer.
    always_ff @(posedge clk) begin
        if (reset && sti_we) begin
            sti_mem[word_cnt_q] <= bus.in_data;
        end
    end

    dt_res_ram u_res_ram (
        .clk     (clk),
        .we      (ram_we && reset),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (bus.res_addr),
        .rdata_a (bus.res_di),
        .raddr_b (res_cnt_q),
        .rdata_b (dump_rdata)
    );

    assign bus.sti_di    = sti_mem[bus.sti_addr];
    assign bus.in_ready  = (state_q == LOAD) && !words_done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dt_reset  = dt_reset_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_dt_mem_host.sv
// Directed bench for dt_mem_host: load, clear, engine port, dump and reset abort.
module tb_dt_mem_host;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dt_mem_host_if bus ();

    dt_mem_host dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs a full load: word k gets data from job_sel; valid_every=2 toggles in_valid.
    task automatic do_load(input int job_sel, input int valid_every, output int load_cycles,
                           output int words);
        int n;
        logic acc;
        logic [15:0] d;
        n = 0;
        words = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        // done during LOAD must be ignored
        bus.done = 1'b1;
        while (bus.dt_reset !== 1'b1 && n < 20000) begin
            if (n == 4) bus.done = 1'b0;
            d = (job_sel == 1) ? ((words == 5) ? 16'h8001 : 16'(words)) : 16'h0000;
            bus.in_valid = ((n % valid_every) == 0) && (words < 1024);
            bus.in_data  = d;
            #1;
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) words++;
            n++;
        end
        bus.in_valid = 1'b0;
        load_cycles = n - 1;
    endtask

    // Dumps the whole map; expected values come from the three directed writes of job 1.
    task automatic do_dump(input int job_sel, input int stall_every);
        int b;
        int n;
        int bad_data;
        int bad_last;
        logic [7:0] exp_d;
        logic acc;
        b = 0;
        n = 0;
        bad_data = 0;
        bad_last = 0;
        while (b < 16384 && n < 40000) begin
            bus.out_ready = (stall_every == 0) || ((n % stall_every) != 0);
            #1;
            if (bus.out_valid) begin
                exp_d = 8'h00;
                if (job_sel == 1) begin
                    if (b == 0)     exp_d = 8'h3c;
                    if (b == 300)   exp_d = 8'h07;
                    if (b == 16383) exp_d = 8'ha5;
                end
                if (bus.out_data !== exp_d) bad_data++;
                if (bus.out_last !== (b == 16383)) bad_last++;
                if (job_sel == 1 && b == 300) check("beat300_data", bus.out_data, 8'h07);
                if (b == 16383) check("last_beat_flag", bus.out_last, 1'b1);
            end
            acc = bus.out_valid && bus.out_ready;
            tick();
            if (acc) b++;
            n++;
        end
        bus.out_ready = 1'b0;
        check("dump_beats", b, 16384);
        check("dump_data_bad", bad_data, 0);
        check("dump_last_bad", bad_last, 0);
        check("dump_end_busy", bus.busy, 1'b0);
        check("dump_end_valid", bus.out_valid, 1'b0);
    endtask

    initial begin
        int lc;
        int w;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.done = 1'b0;
        bus.sti_rd = 1'b0;
        bus.sti_addr = '0;
        bus.res_wr = 1'b0;
        bus.res_rd = 1'b0;
        bus.res_addr = '0;
        bus.res_do = '0;
        repeat (3) tick();

        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_dt_reset", bus.dt_reset, 1'b0);
        reset = 1'b1;
        tick();

        // Job A: aborted by reset after 500 words.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("loadA_busy", bus.busy, 1'b1);
        check("loadA_in_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            bus.in_data = 16'ha000 | 16'(k);
            tick();
        end
        reset = 1'b0;
        tick();
        check("abort_busy", bus.busy, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b0);
        check("abort_dt_reset", bus.dt_reset, 1'b0);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();

        // Job B: in_valid every other cycle; LOAD still bounded by the clear.
        do_load(1, 2, lc, w);
        check("loadB_cycles", lc, 16384);
        check("loadB_words", w, 1024);
        check("run_in_ready", bus.in_ready, 1'b0);
        check("run_busy", bus.busy, 1'b1);

        bus.sti_addr = 10'd5;
        #1;
        check("sti_word5", bus.sti_di, 16'h8001);
        check("sti_pixel80", bus.sti_di[15], 1'b1);
        bus.sti_addr = 10'd0;
        #1;
        check("sti_word0", bus.sti_di, 16'h0000);
        bus.sti_addr = 10'd499;
        #1;
        check("sti_word499_reloaded", bus.sti_di, 16'd499);
        bus.sti_addr = 10'd1023;
        #1;
        check("sti_word1023", bus.sti_di, 16'd1023);

        bus.res_addr = 14'd300;
        bus.res_do = 8'd7;
        bus.res_wr = 1'b1;
        #1;
        check("res_same_cycle_old", bus.res_di, 8'd0);
        tick();
        bus.res_wr = 1'b0;
        #1;
        check("res_next_cycle_new", bus.res_di, 8'd7);
        bus.res_wr = 1'b1;
        bus.res_addr = 14'd0;
        bus.res_do = 8'h3c;
        tick();
        bus.res_addr = 14'd16383;
        bus.res_do = 8'ha5;
        tick();
        bus.res_wr = 1'b0;
        #1;
        check("res_last_written", bus.res_di, 8'ha5);

        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("dump_entry_dt_reset", bus.dt_reset, 1'b0);
        check("dump_entry_valid", bus.out_valid, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", bus.out_valid, 1'b1);
            check("stall_data", bus.out_data, 8'h3c);
            check("stall_last", bus.out_last, 1'b0);
            tick();
        end
        do_dump(1, 5);

        // Writes outside RUN are ignored.
        bus.res_addr = 14'd10;
        bus.res_do = 8'd99;
        bus.res_wr = 1'b1;
        tick();
        bus.res_wr = 1'b0;
        #1;
        check("idle_write_ignored", bus.res_di, 8'd0);

        // Job C: blank image, no engine writes; result map must read back all zero.
        do_load(2, 1, lc, w);
        check("loadC_cycles", lc, 16384);
        check("loadC_words", w, 1024);
        bus.sti_addr = 10'd5;
        #1;
        check("sti_word5_blank", bus.sti_di, 16'h0000);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        do_dump(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dt_mem_host.md
Name: dt_mem_host

Overview:
- Memory-side responder for the distance-transform engine's two memory interfaces.
- Owns the 128x128 binary source image (packed 16-bit words) and the 128x128 8-bit result map.
- Loads the image from a host stream and clears the result map, then releases the engine from reset.
- Serves the engine's sti/res accesses, waits for done, then streams the result map back to the host.

Parameters:
- IMG_W, 128, image width in pixels; power of 2, multiple of STI_DW.
- IMG_H, 128, image height in pixels.
- STI_DW, 16, source word width (pixels per word).
- RES_DW, 8, result pixel width.
- STI_AW, 10, sti address width = log2(IMG_W*IMG_H/STI_DW).
- RES_AW, 14, res address width = log2(IMG_W*IMG_H).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new job from IDLE.
- in_valid  in  1  host source-word valid.
- in_data  in  STI_DW  source word; bit STI_DW-1 is the leftmost pixel, 1 = object.
- in_ready  out  1  host source-word ready.
- out_valid  out  1  result pixel valid.
- out_data  out  RES_DW  result pixel, raster order.
- out_last  out  1  high with the final pixel (address RES_AW'all-ones).
- out_ready  in  1  host accepts the result pixel.
- busy  out  1  high in every state except IDLE.
- dt_reset  out  1  active-low reset driven to the engine's reset input.
- done  in  1  engine completion flag.
- sti_rd  in  1  engine source read strobe; informational only.
- sti_addr  in  STI_AW  engine source word address.
- sti_di  out  STI_DW  source word to the engine.
- res_wr  in  1  engine result write enable.
- res_rd  in  1  engine result read strobe; informational only.
- res_addr  in  RES_AW  engine result address.
- res_do  in  RES_DW  engine write data.
- res_di  out  RES_DW  result word to the engine.

Behaviour:
- Reset (reset==0 at a clock edge) forces:
  - state IDLE;
  - in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, dt_reset=0.
  - Memory contents are not reset.
  - Reset mid-job aborts immediately; any partial transfer is discarded.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD: in_ready=1 until all 1024 words are accepted.
    - Word k is written to sti[k] on an edge where in_valid&&in_ready; word counter wraps 1023 -> done flag.
    - In parallel, the clear counter writes 0 to res[c] every cycle, c = 0..16383, independent of host handshake.
    - LOAD -> RUN on the first edge at which both word count and clear are complete; in_ready drops that same edge.
  - RUN: dt_reset=1, registered, so the engine leaves reset one cycle after entering RUN.
    - Engine port is live: res[res_addr] <= res_do on any edge with res_wr=1.
    - RUN -> DUMP on an edge with done=1 sampled; dt_reset returns to 0 on that edge.
  - DUMP: out_data is registered from res[dump_addr].
    - out_valid rises one cycle after entering DUMP.
    - The beat advances only on out_valid&&out_ready; out_data and out_last are held stable while stalled.
    - DUMP -> IDLE on the edge accepting the out_last beat; out_valid and out_last drop that edge.
- Read timing:
  - sti_di = sti[sti_addr] and res_di = res[res_addr], combinational, zero latency, independent of sti_rd/res_rd.
  - Same-cycle write and read to one address: res_di shows the old value; the new value is visible next cycle.
- Engine-side signals outside RUN: res_wr ignored, sti_di/res_di still reflect addressed contents.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (in_ready=0).
- done asserted before RUN is ignored.
- Arithmetic: all counters unsigned and exact width (STI_AW, RES_AW); no saturation needed.

Decomposition:
- Package dt_pkg holds:
  - IMG_W, IMG_H, STI_DW, RES_DW, STI_AW, RES_AW;
  - the state enum {IDLE, LOAD, RUN, DUMP}.
- One sub-module, dt_res_ram: 16384x8, one write port, asynchronous read port for the engine, second asynchronous read port for dump, write-old-read semantics.
- The sti array stays inline.

Test Plan:
- Reset held low mid-LOAD (after 500 words) -> next cycle IDLE, in_ready=0, busy=0, dt_reset=0; a new start reloads from word 0.
- start, 1024 words with in_valid toggling every other cycle -> LOAD lasts exactly 16384 cycles (clear bound); dt_reset=1 one cycle after RUN entry.
- Load word 5 = 16'h8001, then drive sti_addr=5 -> sti_di=16'h8001 in the same cycle; pixel (x=80, y=0) seen as object via bit 15.
- In RUN: res_wr=1, res_addr=14'd300, res_do=8'd7, while also reading address 300 -> res_di=0 that cycle, 7 the next.
- Assert done, hold out_ready=0 for 10 cycles -> out_valid=1 with out_data=res[0] stable; then out_ready=1 -> 16384 beats, res[300]=7 on beat 300, out_last only on beat 16383, then IDLE.
- Result cleared between jobs: second job with an all-background image and no writes -> all 16384 dumped values = 0.
